seq_divider_64_32: RTL
======================

Name: seq_divider_64_32

Overview:
Sequential radix-2 restoring divider, the inverse of the 32x32 Dadda multiplier. It divides a 64-bit dividend by a 32-bit divisor and returns a 32-bit quotient and 32-bit remainder. Any multiplier product plus a remainder smaller than the divisor round-trips: A = Q*B + R. Sits beside the multiplier in the arithmetic unit; uses valid/ready handshakes on input and output.

Parameters:
WIDTH, 32, divisor/quotient/remainder width; dividend is 2*WIDTH bits
CNT_W, 5, iteration counter width, equal to clog2(WIDTH)

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands A and B are valid
in_ready  output  1  divider can accept an operation
A  input  2*WIDTH  dividend
B  input  WIDTH  divisor
out_valid  output  1  result registers hold a valid result
out_ready  input  1  consumer accepts the result
Q  output  WIDTH  quotient
R  output  WIDTH  remainder
DIV0  output  1  B was zero
OVF  output  1  quotient overflow, A[63:32] >= B with B != 0
busy  output  1  high in CALC or DONE

Behaviour:
- Reset values: out_valid=0, Q=0, R=0, DIV0=0, OVF=0, busy=0, in_ready=1. State returns to IDLE and the counter clears to 0.
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. When rst is asserted in any state, an in-flight operation is discarded and no result is produced. rst has priority over every other event.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE) and is combinational from state only.
- IDLE: when in_valid & in_ready, the operation is accepted at that edge.
  - If B==0: go to DONE with DIV0=1, OVF=0, Q=all ones, R=A[31:0].
  - Else if A[63:32] >= B: go to DONE with OVF=1, DIV0=0, Q=all ones, R=A[31:0].
  - Otherwise: load rem=A[63:32] and qsh=A[31:0], latch B, clear cnt, go to CALC.
- Error latency: out_valid is high in the cycle right after the accepting edge.
- CALC, one step per cycle:
  - t = {rem, qsh[MSB]}, a WIDTH+1 bit value.
  - If t >= {0,B}: rem <= t - B (low WIDTH bits) and the quotient bit is 1. Else rem <= t[WIDTH-1:0] and the quotient bit is 0.
  - qsh <= {qsh[WIDTH-2:0], qbit}. cnt increments.
  - At cnt==WIDTH-1, the step executes and the state moves to DONE. Q and R are loaded from qsh and rem.
- Normal latency: out_valid rises after exactly WIDTH (32) edges following the accepting edge.
- Remainder range: rem < B holds in every cycle. The comparison carries the extra bit, so there is no width truncation error.
- DONE: out_valid=1. Q, R, DIV0 and OVF stay stable while out_ready=0, for any number of cycles.
  - On out_valid & out_ready, go to IDLE. out_valid drops next cycle.
  - Q, R and the flags keep their last values after the transfer, but are only meaningful while out_valid=1.
  - No new operation is accepted in the same cycle as the output transfer. in_ready rises the cycle after.
- in_valid while in CALC or DONE is ignored, and A/B changes have no effect; operands are latched.
- Quotient is unsigned only; there is no signed mode.

Decomposition:
- Shared package: WIDTH default, the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2), and the all-ones quotient constant for error results.
- Natural sub-module: div_step. It is purely combinational: takes rem, the incoming dividend bit and B; returns the next rem and the quotient bit. The FSM, counter and handshake live in the top module.

Test Plan:
1. A=100, B=7, out_ready=1 -> Q=14, R=2, DIV0=0, OVF=0. out_valid rises exactly 32 cycles after acceptance and is high for 1 cycle.
2. A=64'hFFFFFFFE_00000001, B=32'hFFFFFFFF -> Q=32'hFFFFFFFF, R=0. Max-operand round trip against the multiplier output.
3. A=64'h12345678_9ABCDEF0, B=0 -> DIV0=1, Q=32'hFFFFFFFF, R=32'h9ABCDEF0, out_valid 1 cycle after accept. Then A=64'h00000005_00000000, B=5 -> OVF=1, Q=32'hFFFFFFFF, R=0.
4. A=1000, B=3, out_ready held 0 for 10 cycles after out_valid -> Q=333, R=1 stable throughout, in_ready=0. After out_ready=1, in_ready=1 on the next cycle. A back-to-back op A=9, B=9 gives Q=1, R=0.
5. Assert rst for 1 cycle at iteration 10 of A=500, B=13 -> next cycle out_valid=0, in_ready=1, busy=0. A new op A=500, B=13 then yields Q=38, R=6 with no stale result.
6. 1000 random operand pairs with A[63:32] < B, B != 0, random out_ready -> Q*B + R == A and R < B every time. Scoreboard uses a behavioural model and the Dadda multiplier for Q*B.

Source files
------------

// File: rtl/seq_divider_64_32_pkg.sv
// Shared definitions for the sequential 64/32 restoring divider:
// default widths, FSM encoding and the error-result quotient.
package seq_divider_64_32_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Quotient reported for divide-by-zero and quotient overflow.
  localparam logic [WIDTH-1:0] QUOT_ONES = '1;

endpackage

// File: rtl/seq_divider_64_32_div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module seq_divider_64_32_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;

  // The extra top bit keeps the compare exact even when rem has its MSB set.
  assign t        = {rem, din};
  assign diff     = t - {1'b0, b};
  assign qbit     = (t >= {1'b0, b});
  assign rem_next = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/seq_divider_64_32.sv
// Sequential unsigned 64/32 divider, one quotient bit per cycle, with
// valid/ready handshakes on the operand and result sides.
module seq_divider_64_32
  import seq_divider_64_32_pkg::*;
#(
  parameter int WIDTH = seq_divider_64_32_pkg::WIDTH,
  parameter int CNT_W = seq_divider_64_32_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]   R,
  output logic               DIV0,
  output logic               OVF,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; operands are latched at that edge, and the result is held
  // unchanged from out_valid rising until the edge that sees out_ready.

  localparam logic [WIDTH-1:0] Q_ONES = '1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, qsh, b_q;
  logic [WIDTH-1:0] q_q, r_q;
  logic             div0_q, ovf_q;
  logic [WIDTH-1:0] rem_next;
  logic             qbit;
  logic             accept, b_zero, quot_ovf, last_step;

  assign accept    = in_valid && (state == ST_IDLE);
  assign b_zero    = (B == '0);
  assign quot_ovf  = !b_zero && (A[2*WIDTH-1:WIDTH] >= B);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  seq_divider_64_32_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .din      (qsh[WIDTH-1]),
    .b        (b_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (b_zero || quot_ovf) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      qsh    <= '0;
      b_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (b_zero || quot_ovf) begin
              div0_q <= b_zero;
              ovf_q  <= quot_ovf;
              q_q    <= Q_ONES;
              r_q    <= A[WIDTH-1:0];
            end else begin
              rem    <= A[2*WIDTH-1:WIDTH];
              qsh    <= A[WIDTH-1:0];
              b_q    <= B;
              cnt    <= '0;
              div0_q <= 1'b0;
              ovf_q  <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          rem <= rem_next;
          qsh <= {qsh[WIDTH-2:0], qbit};
          cnt <= cnt + 1'b1;
          if (last_step) begin
            q_q <= {qsh[WIDTH-2:0], qbit};
            r_q <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign Q         = q_q;
  assign R         = r_q;
  assign DIV0      = div0_q;
  assign OVF       = ovf_q;
  assign state_dbg = state;

endmodule
